// File: rtl/psk_pkg.sv
// psk_pkg: shared constants and state type for the PSK frame bit generator.
package psk_pkg;
  localparam logic [12:0] BARKER13 = 13'b1111100110101;
  localparam int PN9_TAP_OUT = 8;
  localparam int PN9_TAP_FB = 4;
  localparam logic [8:0] PN9_SEED_DEF = 9'h1FF;
  typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_HEADER, S_PAYLOAD, S_GAP} state_t;
endpackage

// File: rtl/pn9_lfsr.sv
// pn9_lfsr: PN9 payload source; steps only when advance is high.
module pn9_lfsr import psk_pkg::*; #(
  parameter logic [8:0] SEED = PN9_SEED_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic advance,
  output logic pn_bit
);
  logic [8:0] s_q, s_d;
  always_comb s_d = load ? SEED : advance ? {s_q[7:0], s_q[PN9_TAP_OUT] ^ s_q[PN9_TAP_FB]} : s_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s_q <= SEED;
    else s_q <= s_d;
  assign pn_bit = s_q[PN9_TAP_OUT];
endmodule

// File: rtl/psk_frame_bitgen.sv
// psk_frame_bitgen: framed NRZ/DPSK bit source (Barker-13, length header, PN9 payload, zero gap).
module psk_frame_bitgen import psk_pkg::*; #(
  parameter int PAYLOAD_LEN = 64,
  parameter int GAP_LEN = 8,
  parameter logic [8:0] PN_SEED = PN9_SEED_DEF
) (
  input  logic        clk32M768,
  input  logic        rst_n,
  input  logic        sym_ce,
  input  logic        en,
  output logic        bit_out,
  output logic        diff_out,
  output logic        bit_valid,
  output logic        sof,
  output logic        busy,
  output logic [15:0] frame_cnt
);
  localparam logic [7:0] HDR = 8'(PAYLOAD_LEN);
  localparam logic [7:0] PL_LAST = 8'(PAYLOAD_LEN - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_LEN - 1);
  state_t state_q, state_d, st, nxt;
  logic [7:0] cnt_q, cnt_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic bit_q, bit_d, d_q, d_d, valid_q, valid_d, sof_q, sof_d;
  logic emit, last, b, adv, pn_bit;
  logic [3:0] pre_idx;
  logic [2:0] hdr_idx;
  pn9_lfsr #(.SEED(PN_SEED)) u_pn (
    .clk(clk32M768), .rst_n(rst_n), .load(1'b0), .advance(adv), .pn_bit(pn_bit)
  );
  // An enabled IDLE behaves as the first preamble slot so the first bit leaves on that sym_ce.
  always_comb begin
    st = (state_q == S_IDLE && en) ? S_PREAMBLE : state_q;
    emit = sym_ce && st != S_IDLE;
    pre_idx = 4'd12 - cnt_q[3:0];
    hdr_idx = ~cnt_q[2:0];
    b = 1'b0;
    last = 1'b0;
    nxt = st;
    case (st)
      S_PREAMBLE: begin b = BARKER13[pre_idx]; last = cnt_q == 8'd12; nxt = S_HEADER; end
      S_HEADER: begin b = HDR[hdr_idx]; last = cnt_q == 8'd7; nxt = S_PAYLOAD; end
      S_PAYLOAD: begin b = pn_bit; last = cnt_q == PL_LAST; nxt = GAP_LEN != 0 ? S_GAP : en ? S_PREAMBLE : S_IDLE; end
      S_GAP: begin last = cnt_q == GAP_LAST; nxt = en ? S_PREAMBLE : S_IDLE; end
      default: ;
    endcase
    state_d = emit ? (last ? nxt : st) : state_q;
    cnt_d = emit ? (last ? 8'd0 : cnt_q + 8'd1) : cnt_q;
    bit_d = emit ? b : bit_q;
    d_d = d_q ^ (emit & b);
    valid_d = emit;
    sof_d = emit && st == S_PREAMBLE && cnt_q == 8'd0;
    adv = emit && st == S_PAYLOAD;
    fcnt_d = fcnt_q + 16'(adv && last);
  end
  always_ff @(posedge clk32M768 or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      fcnt_q <= '0;
      bit_q <= 1'b0;
      d_q <= 1'b0;
      valid_q <= 1'b0;
      sof_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      fcnt_q <= fcnt_d;
      bit_q <= bit_d;
      d_q <= d_d;
      valid_q <= valid_d;
      sof_q <= sof_d;
    end
  assign bit_out = bit_q;
  assign diff_out = d_q;
  assign bit_valid = valid_q;
  assign sof = sof_q;
  assign busy = state_q != S_IDLE;
  assign frame_cnt = fcnt_q;
endmodule

// File: tb/tb_psk_frame_bitgen.sv
// tb_psk_frame_bitgen: randomized-timing bench against a queue-based frame model.
module tb_psk_frame_bitgen;
  logic clk = 1'b0, rst_n = 1'b0, sym_ce = 1'b0, en = 1'b0, sel = 1'b0;
  logic a_bit, a_diff, a_valid, a_sof, a_busy, b_bit, b_diff, b_valid, b_sof, b_busy;
  logic [15:0] a_fcnt, b_fcnt;
  logic o_bit, o_diff, o_valid, o_sof, o_busy;
  logic [15:0] o_fcnt;
  int checks = 0, errors = 0;
  typedef struct { bit b; bit sof; int fc; } ex_t;
  ex_t exp_q[$];
  int m_pn, m_fc;
  bit m_d, last_b;
  always #5 clk = ~clk;
  psk_frame_bitgen u_a (
    .clk32M768(clk), .rst_n(rst_n), .sym_ce(sym_ce), .en(en), .bit_out(a_bit), .diff_out(a_diff),
    .bit_valid(a_valid), .sof(a_sof), .busy(a_busy), .frame_cnt(a_fcnt)
  );
  psk_frame_bitgen #(.PAYLOAD_LEN(1), .GAP_LEN(0)) u_b (
    .clk32M768(clk), .rst_n(rst_n), .sym_ce(sym_ce), .en(en), .bit_out(b_bit), .diff_out(b_diff),
    .bit_valid(b_valid), .sof(b_sof), .busy(b_busy), .frame_cnt(b_fcnt)
  );
  assign o_bit = sel ? b_bit : a_bit;
  assign o_diff = sel ? b_diff : a_diff;
  assign o_valid = sel ? b_valid : a_valid;
  assign o_sof = sel ? b_sof : a_sof;
  assign o_busy = sel ? b_busy : a_busy;
  assign o_fcnt = sel ? b_fcnt : a_fcnt;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic void build_frame(input int plen, input int glen);
    logic [12:0] bk = 13'b1111100110101;
    logic [7:0] h = 8'(plen);
    ex_t e;
    for (int i = 0; i < 13; i++) begin e.b = bk[12-i]; e.sof = (i == 0); e.fc = m_fc; exp_q.push_back(e); end
    for (int i = 0; i < 8; i++) begin e.b = h[7-i]; e.sof = 0; e.fc = m_fc; exp_q.push_back(e); end
    for (int i = 0; i < plen; i++) begin
      e.b = bit'((m_pn >> 8) & 1);
      m_pn = ((m_pn << 1) | int'(e.b ^ bit'((m_pn >> 4) & 1))) & 'h1FF;
      if (i == plen - 1) m_fc = (m_fc + 1) & 'hFFFF;
      e.sof = 0; e.fc = m_fc; exp_q.push_back(e);
    end
    for (int i = 0; i < glen; i++) begin e.b = 0; e.sof = 0; e.fc = m_fc; exp_q.push_back(e); end
  endfunction
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sym_ce = 1'b0;
    #1;
    chk("rst_bit", o_bit, 0); chk("rst_diff", o_diff, 0); chk("rst_valid", o_valid, 0);
    chk("rst_sof", o_sof, 0); chk("rst_busy", o_busy, 0); chk("rst_fcnt", o_fcnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    m_pn = 'h1FF; m_fc = 0; m_d = 0; last_b = 0;
  endtask
  task automatic emit();
    ex_t e;
    if (exp_q.size() == 0) begin chk("model_empty", 1, 0); return; end
    e = exp_q.pop_front();
    @(negedge clk);
    sym_ce = 1'b1;
    @(posedge clk);
    #1;
    m_d ^= e.b;
    last_b = e.b;
    chk("valid", o_valid, 1); chk("bit", o_bit, e.b); chk("diff", o_diff, m_d);
    chk("sof", o_sof, e.sof); chk("fcnt", o_fcnt, e.fc);
  endtask
  task automatic quiet(input int n, input logic ce);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sym_ce = ce;
      @(posedge clk);
      #1;
      chk("no_valid", o_valid, 0); chk("hold_bit", o_bit, last_b);
    end
  endtask
  initial begin
    logic [20:0] got21;
    int k;
    // Fixed sym_ce every 4 cycles, two frames, en dropped during frame 2.
    sel = 0;
    do_reset();
    en = 1'b1;
    build_frame(64, 8); build_frame(64, 8);
    for (int i = 1; i <= 186; i++) begin
      if (i == 150) en = 1'b0;
      emit();
      if (i <= 21) got21[21-i] = o_bit;
      if (i == 1) chk("busy_run", o_busy, 1);
      quiet(3, 1'b0);
    end
    chk("first21", got21, 21'b1111100110101_01000000);
    chk("busy_end_a", o_busy, 0);
    quiet(4, 1'b1);
    // Random sym_ce spacing; en dropped mid payload; frame 2 continues the PN sequence.
    do_reset();
    en = 1'b1;
    build_frame(64, 8);
    k = $urandom_range(22, 85);
    for (int i = 1; i <= 93; i++) begin
      if (i == k) en = 1'b0;
      emit();
      if (i == 92) chk("busy_gap", o_busy, 1);
      quiet($urandom_range(0, 3), 1'b0);
    end
    chk("busy_fall", o_busy, 0);
    quiet(5, 1'b1);
    chk("busy_idle", o_busy, 0);
    en = 1'b1;
    build_frame(64, 8);
    for (int i = 1; i <= 93; i++) begin
      if (i == 40) en = 1'b0;
      emit();
      quiet($urandom_range(0, 2), 1'b0);
    end
    chk("fcnt_two", o_fcnt, 2);
    // Asynchronous reset mid-header, then restart from seed.
    do_reset();
    en = 1'b1;
    build_frame(64, 8);
    k = 13 + $urandom_range(1, 7);
    for (int i = 1; i <= k; i++) begin emit(); quiet(1, 1'b0); end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_bit", o_bit, 0); chk("arst_diff", o_diff, 0); chk("arst_valid", o_valid, 0);
    chk("arst_sof", o_sof, 0); chk("arst_busy", o_busy, 0); chk("arst_fcnt", o_fcnt, 0);
    do_reset();
    build_frame(64, 8);
    for (int i = 1; i <= 40; i++) begin emit(); quiet(3, 1'b0); end
    en = 1'b0;
    // Back-to-back symbols on the short-frame instance.
    sel = 1;
    do_reset();
    en = 1'b1;
    build_frame(1, 0); build_frame(1, 0); build_frame(1, 0);
    for (int i = 1; i <= 66; i++) begin
      if (i == 66) en = 1'b0;
      emit();
    end
    quiet(3, 1'b1);
    chk("busy_end_b", o_busy, 0);
    chk("fcnt_b", o_fcnt, 3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/psk_frame_bitgen.md
PSK_FRAME_BITGEN -- requirements
Module: psk_frame_bitgen

Interface
REQ-001 SHALL provide parameter PAYLOAD_LEN, default 64, payload bits per frame, legal range 1..255.
REQ-002 SHALL provide parameter GAP_LEN, default 8, zero bits after each payload, legal range 0..255.
REQ-003 SHALL provide parameter PN_SEED, default 9'h1FF, PN9 load value, nonzero.
REQ-004 SHALL have port clk32M768  in  1  single system clock, all logic on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port sym_ce  in  1  one-cycle symbol-rate clock-enable pulse from the clock-enable divider; any rate up to every cycle.
REQ-007 SHALL have port en  in  1  level; request continuous framing.
REQ-008 SHALL have port bit_out  out  1  current NRZ symbol bit.
REQ-009 SHALL have port diff_out  out  1  differentially encoded bit, for DPSK.
REQ-010 SHALL have port bit_valid  out  1  one-cycle pulse marking a new bit_out/diff_out.
REQ-011 SHALL have port sof  out  1  pulse coincident with bit_valid on the first preamble bit.
REQ-012 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-013 SHALL have port frame_cnt  out  16  completed-frame count.

Function
REQ-014 SHALL implement states IDLE, PREAMBLE, HEADER, PAYLOAD, GAP; all transitions occur only on cycles with sym_ce=1.
REQ-015 SHALL ignore sym_ce in IDLE unless en=1; with en=1 and sym_ce=1 in IDLE, SHALL emit the first preamble bit on that sym_ce.
REQ-016 SHALL register outputs: bit_out, diff_out, bit_valid and sof update on the edge sampling sym_ce=1, so bit_valid rises one cycle after sym_ce; bit_out/diff_out hold between pulses.
REQ-017 PREAMBLE SHALL send 13-bit Barker 1111100110101, MSB first.
REQ-018 HEADER SHALL send PAYLOAD_LEN as 8 bits, MSB first.
REQ-019 PAYLOAD SHALL send PAYLOAD_LEN PN9 bits: state s[8:0], output s[8], feedback s[8]^s[4], shift s <= {s[7:0], fb}; the LFSR advances only on emitted payload bits and continues across frames.
REQ-020 GAP SHALL send GAP_LEN zero bits with bit_valid pulsing; with GAP_LEN=0 the GAP state SHALL be skipped.
REQ-021 At end of frame, SHALL enter PREAMBLE with the next sym_ce if en=1, else IDLE; deasserting en mid-frame SHALL complete the current frame including gap.
REQ-022 SHALL compute diff_out as d[n] = d[n-1] XOR bit_out[n] on every emitted bit, including gap bits; d persists across frames.
REQ-023 frame_cnt SHALL increment on the last payload bit and wrap 16'hFFFF to 0.
REQ-024 Back-to-back sym_ce every cycle SHALL yield one bit per cycle with no dropped or repeated bits.

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE, bit_out=0, diff_out=0, d=0, bit_valid=0, sof=0, busy=0, frame_cnt=0, LFSR=PN_SEED, all bit counters 0.
REQ-026 Reset mid-frame SHALL abort with no further bit_valid; after release the next frame starts from its first preamble bit with LFSR=PN_SEED.

Structure
REQ-027 Shared package psk_pkg SHALL hold the Barker-13 constant, PN9 tap positions and default seed, and the state enumeration.
REQ-028 SHALL instantiate one sub-module pn9_lfsr (ports: clock, reset, load, advance, bit) for the payload source.

Verification
REQ-029 Reset, en=1, sym_ce every 4 cycles -> first 21 bits 1111100110101 then 01000000; sof on bit 1 only; bit_valid exactly 1 cycle after each sym_ce.
REQ-030 Same run -> payload bits 1-9 = 1, bits 10-14 = 0; frame_cnt=1 after bit 85; 8 zero gap bits; second sof on bit 94.
REQ-031 en dropped during payload of frame 1 -> frame completes through gap, busy falls after last gap bit, no further bit_valid; frame 2 payload resumes the PN sequence, not the seed.
REQ-032 sym_ce every cycle, GAP_LEN=0, PAYLOAD_LEN=1 -> 22-bit frames contiguous, one bit per cycle, diff_out matches reference XOR chain across 3 frames.
REQ-033 rst_n pulsed low asynchronously mid-header -> outputs 0 immediately, busy=0; restart reproduces REQ-029 sequence exactly.
